// File: rtl/sha_rx_pkg.sv
// Shared constants and receiver state type for the UART-to-SHA-256 message front end.
package sha_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
    localparam int unsigned DEFAULT_MAX_BYTES    = 55;

    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] PAD = 8'h80;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 bit-level UART receiver with 2-flop input synchronizer and one-cycle byte strobe.
// Optional macro UART_RX_FRAME_CHECK_EN: drop bytes whose stop bit samples low.
module uart_rx
    import sha_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] data,
    output logic       strobe
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rxd_meta, rxd_sync;
    rx_state_t   state, state_nxt;
    logic [15:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  data_nxt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            state    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            data     <= '0;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            state    <= state_nxt;
            clk_cnt  <= clk_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            data     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 16'd1;
        bit_idx_nxt = bit_idx;
        data_nxt    = data;
        strobe      = 1'b0;
        case (state)
            RX_IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (!rxd_sync) state_nxt = RX_START;
            end
            RX_START: begin
                // a line that is high again at mid start bit was only a glitch
                if (clk_cnt == HALF_BIT) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    data_nxt    = {rxd_sync, data[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = RX_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (rxd_sync) strobe = 1'b1;
                    else          state_nxt = RX_WAIT_IDLE;
`else
                    strobe = 1'b1;
`endif
                end
            end
            RX_WAIT_IDLE: begin
                clk_cnt_nxt = '0;
                if (rxd_sync) state_nxt = RX_IDLE;
            end
            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_msg_rx.sv
// Collects UART bytes into one SHA-256-padded 512-bit block, terminated by LF.
// Optional macro UART_RX_FRAME_CHECK_EN is forwarded to the bit-level receiver.
module uart_msg_rx
    import sha_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned MAX_BYTES    = DEFAULT_MAX_BYTES
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         RXD,
    input  logic         msg_ready,
    output logic [0:511] msg,
    output logic         msg_valid,
    output logic         overflow
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    logic [7:0]       rx_data;
    logic             rx_strobe;
    logic [7:0]       mem [MAX_BYTES];
    logic [CNT_W-1:0] count, cnt_eff;
    logic             accept, take, is_lf, is_cr, store;
    logic [0:511]     blk;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLK    (CLK),
        .reset  (reset),
        .RXD    (RXD),
        .data   (rx_data),
        .strobe (rx_strobe)
    );

    // on acceptance the incoming byte already belongs to the next message
    assign accept  = msg_valid && msg_ready;
    assign cnt_eff = accept ? '0 : count;
    assign take    = rx_strobe && (!msg_valid || accept);
    assign is_lf   = (rx_data == LF);
    assign is_cr   = (rx_data == CR);
    assign store   = take && !is_lf && !is_cr && (cnt_eff < CNT_W'(MAX_BYTES));

    always_ff @(posedge CLK) begin
        if (store) mem[cnt_eff] <= rx_data;
    end

    always_comb begin
        blk = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < 32'(cnt_eff)) blk[8*i +: 8] = mem[i];
        end
        blk[int'(cnt_eff)*8 +: 8] = PAD;
        blk[448 +: 64]            = 64'(cnt_eff) << 3;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            msg       <= '0;
            msg_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count <= cnt_eff;
            if (accept) begin
                msg_valid <= 1'b0;
                overflow  <= 1'b0;
            end
            if (take) begin
                if (is_lf) begin
                    msg       <= blk;
                    msg_valid <= 1'b1;
                end else if (!is_cr) begin
                    if (store) count    <= cnt_eff + 1'b1;
                    else       overflow <= 1'b1;
                end
            end
        end
    end

endmodule
